// File: rtl/det_nms_3x3.sv
// 3x3 non-maximum suppression over a raster-ordered Hessian determinant stream.
// Emits thresholded local maxima with coordinates, an end-of-frame pulse and a per-frame count.
module det_nms_3x3 #(
  parameter int unsigned                  DATA_WIDTH  = 32,
  parameter int unsigned                  IMG_WIDTH   = 640,
  parameter int unsigned                  IMG_HEIGHT  = 480,
  parameter int unsigned                  COORD_WIDTH = 10,
  parameter logic signed [DATA_WIDTH-1:0] THRESHOLD   = 32'sd4096,
  parameter int unsigned                  CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  det_d_i,
  input  logic                          det_d_i_valid,
  output logic                          kp_valid,
  output logic        [COORD_WIDTH-1:0] kp_x,
  output logic        [COORD_WIDTH-1:0] kp_y,
  output logic signed [DATA_WIDTH-1:0]  kp_det,
  output logic                          frame_done,
  output logic        [CNT_WIDTH-1:0]   kp_cnt
);

  logic signed [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  // win[row][col]: row 0 is the oldest line, col 2 the newest column
  logic signed [DATA_WIDTH-1:0] win [3][3];

  logic [COORD_WIDTH-1:0] col, row;
  logic [COORD_WIDTH-1:0] cx, cy;
  logic                   win_rdy;
  logic                   last_px;
  logic [CNT_WIDTH-1:0]   run_cnt;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   hit;
  logic                   last_col, last_row;

  assign last_col = (col == COORD_WIDTH'(IMG_WIDTH - 1));
  assign last_row = (row == COORD_WIDTH'(IMG_HEIGHT - 1));

  always_comb begin
    hit = win_rdy && (win[1][1] > THRESHOLD);
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1) && !(win[1][1] > win[r][c])) hit = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_inc = run_cnt;
    if (hit && (run_cnt != '1)) cnt_inc = run_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && det_d_i_valid) begin
      lb1[col] <= lb0[col];
      lb0[col] <= det_d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      cx         <= '0;
      cy         <= '0;
      win_rdy    <= 1'b0;
      last_px    <= 1'b0;
      run_cnt    <= '0;
      kp_valid   <= 1'b0;
      kp_x       <= '0;
      kp_y       <= '0;
      kp_det     <= '0;
      frame_done <= 1'b0;
      kp_cnt     <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else begin
      win_rdy <= 1'b0;
      last_px <= 1'b0;
      if (det_d_i_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + COORD_WIDTH'(1);
        end else begin
          col <= col + COORD_WIDTH'(1);
        end
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1[col];
        win[1][2] <= lb0[col];
        win[2][2] <= det_d_i;
        win_rdy   <= (col >= COORD_WIDTH'(2)) && (row >= COORD_WIDTH'(2));
        cx        <= col - COORD_WIDTH'(1);
        cy        <= row - COORD_WIDTH'(1);
        last_px   <= last_col && last_row;
      end

      kp_valid <= hit;
      if (hit) begin
        kp_x   <= cx;
        kp_y   <= cy;
        kp_det <= win[1][1];
      end

      // The final window's keypoint is folded into the count published with frame_done
      frame_done <= last_px;
      if (last_px) begin
        kp_cnt  <= cnt_inc;
        run_cnt <= '0;
      end else begin
        run_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: doc/det_nms_3x3.md
Name: det_nms_3x3

Overview:
- Consumes the raster-ordered Hessian determinant stream of one scale (det value plus valid, one value per pixel).
- Applies a signed threshold and 3x3 spatial non-maximum suppression using two line buffers.
- Emits interest-point candidates (x, y, det) to the downstream scale-space / keypoint stage.
- Also emits an end-of-frame pulse and a per-frame keypoint count.

Parameters:
- DATA_WIDTH, 32, width of signed det value (sign bit, 19 integer bits, 12 fraction bits).
- IMG_WIDTH, 640, pixels per row.
- IMG_HEIGHT, 480, rows per frame.
- COORD_WIDTH, 10, width of column/row counters and output coordinates; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.
- THRESHOLD, 32'sd4096, signed det threshold (1.0 in Q12); a candidate must be strictly greater than it.
- CNT_WIDTH, 16, width of the keypoint counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- det_d_i, input, DATA_WIDTH, signed determinant sample.
- det_d_i_valid, input, 1, sample qualifier; no backpressure, every valid sample is accepted.
- kp_valid, output, 1, one-cycle pulse: a keypoint is present on kp_x / kp_y / kp_det.
- kp_x, output, COORD_WIDTH, keypoint column.
- kp_y, output, COORD_WIDTH, keypoint row.
- kp_det, output, DATA_WIDTH, keypoint det value.
- frame_done, output, 1, one-cycle pulse after the last pixel of a frame.
- kp_cnt, output, CNT_WIDTH, keypoints found in the last completed frame.

Behaviour:
- Reset: sync, active-high.
  - Clears kp_valid, kp_x, kp_y, kp_det, frame_done, kp_cnt, the internal running count, col/row counters, window registers and the window-ready flag.
  - Line buffer contents are not cleared.
  - Reset mid-frame abandons the frame; the next valid sample is pixel (0,0).
- Counters: col increments on each accepted sample; it wraps at IMG_WIDTH-1 to 0 and row increments. Row wraps at IMG_HEIGHT-1 to 0. Samples with det_d_i_valid low change nothing.
- Line buffers: lb0 and lb1, IMG_WIDTH entries each, asynchronous read, indexed by col. On an accepted sample at the edge:
  - lb1[col] <= lb0[col]
  - lb0[col] <= det_d_i
  - the 3x3 window shifts left by one column, loading new column {lb1[col], lb0[col], det_d_i} (top, middle, bottom).
- Window-ready flag is registered on the same edge: set iff the accepted sample has col>=2 and row>=2, otherwise cleared. It is cleared on cycles with no accepted sample. Centre coordinates are latched as (col-1, row-1).
- Compare stage fires on the edge after the window-ready flag is set. kp_valid <= 1 iff both:
  - centre > THRESHOLD (signed compare);
  - centre > each of the 8 neighbours (strict, signed).
- Ties suppress both pixels. Latency is exactly 1 clock after the edge that accepted the completing sample, independent of det_d_i_valid on that cycle.
- kp_x, kp_y, kp_det update only when kp_valid is set and hold otherwise.
- Border pixels (row 0, row IMG_HEIGHT-1, col 0, col IMG_WIDTH-1) never produce keypoints. Windows never straddle rows because col>=2 is required.
- Stale line-buffer data from a previous frame or an abandoned frame is never used, because row>=2 is required.
- frame_done pulses on the edge after the sample at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted, aligned with any keypoint from that sample's window.
  - On the same edge, kp_cnt <= running count (including that final keypoint) and the running count clears to 0.
- Running count saturates at 2^CNT_WIDTH-1.
- Back-to-back valid samples are sustained at 1 sample/clock. Arbitrary gaps in det_d_i_valid are allowed.

Test Plan:
- Bench configuration for all scenarios: IMG_WIDTH=5, IMG_HEIGHT=4, THRESHOLD=100.
- All-zero frame, 20 samples back-to-back -> kp_valid never high; frame_done one pulse 1 clock after sample 20; kp_cnt=0.
- Frame zero except 500 at (2,1) -> exactly one kp_valid, 1 clock after sample index 13 (pixel (3,2)) is accepted, with kp_x=2, kp_y=1, kp_det=500; kp_cnt=1 after frame_done.
- Peak 100 at (2,1), then separately -5 peak on a -1000 background -> no keypoint in either case (strict threshold, signed compare).
- 500 at both (1,1) and (2,1), zeros elsewhere -> no keypoint (tie suppression). 900 at (0,1) and (4,2) -> no keypoint (border).
- Scenario 2 repeated with det_d_i_valid toggling every other cycle -> identical keypoint; kp_valid 1 clock after the edge accepting pixel (3,2).
- rst asserted for 1 cycle after 7 samples, then the full scenario-2 frame -> exactly one keypoint (2,1,500); kp_cnt=1. A second identical frame back-to-back -> kp_cnt=1 again.
